// File: rtl/uart_rx_brk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_brk_pkg
//  Description : Shared receiver state encoding and baud-divider helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_brk_pkg;

    // Receiver states; BRK is the low-line holding state after a bad stop bit
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } rx_state_t;

    // Clock cycles per bit (integer division, truncating)
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Cycles from the start edge to the middle of the start bit
    function automatic int calc_half(input int clk_freq, input int baud);
        return calc_div(clk_freq, baud) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_brk_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_brk_if
//  Description : Byte/status bundle from the UART receiver to its consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_brk_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_break;
    logic       rx_busy;

    // Receiver side drives everything
    modport master (
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_break,
        output rx_busy
    );

    // Command parser side only observes
    modport slave (
        input rx_data,
        input rx_valid,
        input rx_frame_err,
        input rx_break,
        input rx_busy
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_brk_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_brk_sync2
//  Description : Two-flop synchronizer with a configurable reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_brk_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d_i,
    output logic      q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops to settle metastability from the async input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_brk.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_brk
//  Description : 8N1 UART receiver with framing-error and line-break strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_brk
    import uart_rx_brk_pkg::*;
#(
    parameter int CLK_FREQ      = 12000000,
    parameter int UART_BAUDRATE = 9600,
    parameter int BREAK_BITS    = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     uart_rx,
    uart_rx_brk_if.master rx_if
);

    localparam int c_DIV       = calc_div(CLK_FREQ, UART_BAUDRATE);
    localparam int c_HALF      = calc_half(CLK_FREQ, UART_BAUDRATE);
    localparam int c_TW        = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_BRK_CYC_I = BREAK_BITS * c_DIV;
    localparam int c_LW        = $clog2(c_BRK_CYC_I + 1);

    localparam logic [c_TW-1:0] c_HALF_M1 = c_TW'(c_HALF - 1);
    localparam logic [c_TW-1:0] c_DIV_M1  = c_TW'(c_DIV - 1);
    localparam logic [c_LW-1:0] c_BRK_CYC = c_LW'(c_BRK_CYC_I);
    localparam logic [c_LW-1:0] c_BRK_M1  = c_LW'(c_BRK_CYC_I - 1);

    logic             rxs;
    rx_state_t        state_q;
    logic [c_TW-1:0]  timer_q;
    logic [c_LW-1:0]  low_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             ferr_q;
    logic             brk_q;
    logic             busy_q;

    uart_rx_brk_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (uart_rx),
        .q_o (rxs)
    );

    // Frame FSM: bit timing, sampling, strobes and the break low-time counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            low_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;

            // Low time is measured from the start edge and saturates, so a
            // break can be reported only once per low period
            if (state_q != IDLE && low_q != c_BRK_CYC) begin
                low_q <= low_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_q <= START;
                        timer_q <= '0;
                        low_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (timer_q == c_HALF_M1) begin
                        timer_q <= '0;
                        if (rxs) begin
                            // Line already back high at mid start bit: glitch
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                DATA: begin
                    if (timer_q == c_DIV_M1) begin
                        timer_q            <= '0;
                        shift_q[bit_idx_q] <= rxs;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                STOP: begin
                    if (timer_q == c_DIV_M1) begin
                        timer_q <= '0;
                        if (rxs) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            // Bad stop bit: keep the old byte, watch for break
                            ferr_q  <= 1'b1;
                            state_q <= BRK;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                BRK: begin
                    if (rxs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (low_q == c_BRK_M1) begin
                        brk_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.rx_data      = data_q;
    assign rx_if.rx_valid     = valid_q;
    assign rx_if.rx_frame_err = ferr_q;
    assign rx_if.rx_break     = brk_q;
    assign rx_if.rx_busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_brk.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_brk
//  Description : Self-checking bench for uart_rx_brk with an event-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_brk;

    localparam int CLK_FREQ   = 192000;
    localparam int BAUD       = 9600;
    localparam int BREAK_BITS = 16;
    localparam int DIV        = CLK_FREQ / BAUD;
    localparam int HALF       = DIV / 2;
    // Line edge -> 2-cycle synchronizer -> strobe one cycle after the sample
    localparam int LAT_FRAME  = 2 + HALF + 9 * DIV + 1;
    localparam int LAT_BRK    = 2 + BREAK_BITS * DIV + 1;
    localparam int K_VALID    = 0;
    localparam int K_FERR     = 1;
    localparam int K_BRK      = 2;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic uart_rx = 1'b1;
    int   cyc      = 0;
    int   busy_cnt = 0;
    ev_t  obs_q[$];
    ev_t  exp_q[$];
    int   errors    = 0;
    int   checks    = 0;
    int   last_byte = 0;
    int   base      = 0;
    int   busy0     = 0;

    uart_rx_brk_if rx_if ();

    uart_rx_brk #(
        .CLK_FREQ      (CLK_FREQ),
        .UART_BAUDRATE (BAUD),
        .BREAK_BITS    (BREAK_BITS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .rx_if   (rx_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: log every strobe with its cycle, count busy cycles
    always @(negedge clk) begin
        if (rx_if.rx_busy)      busy_cnt <= busy_cnt + 1;
        if (rx_if.rx_valid)     obs_q.push_back('{K_VALID, int'(rx_if.rx_data), cyc});
        if (rx_if.rx_frame_err) obs_q.push_back('{K_FERR,  int'(rx_if.rx_data), cyc});
        if (rx_if.rx_break)     obs_q.push_back('{K_BRK,   int'(rx_if.rx_data), cyc});
    end

    // ---------------- reference model (frame-level rules) ----------------
    task automatic model_byte(input int t, input logic [7:0] b);
        exp_q.push_back('{K_VALID, int'(b), t + LAT_FRAME});
        last_byte = int'(b);
    endtask

    // Line held low for nbits bit times from a start edge at cycle t
    task automatic model_low(input int t, input int nbits);
        if (nbits * DIV > HALF + 9 * DIV + 2)
            exp_q.push_back('{K_FERR, last_byte, t + LAT_FRAME});
        if (nbits > BREAK_BITS)
            exp_q.push_back('{K_BRK, last_byte, t + LAT_BRK});
    endtask

    // ---------------- stimulus primitives ----------------
    task automatic line(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(cyc, b);
        line(1'b0, DIV);
        for (int i = 0; i < 8; i++) line(b[i], DIV);
        line(1'b1, DIV);
    endtask

    task automatic send_low(input int nbits);
        model_low(cyc, nbits);
        line(1'b0, nbits * DIV);
        line(1'b1, 2 * DIV);
    endtask

    task automatic begin_scn;
        base = obs_q.size();
        exp_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL reset rx_data: got %02h, required 00", rx_if.rx_data); end
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset rx_valid: got %b, required 0", rx_if.rx_valid); end
        checks++; if (rx_if.rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset rx_frame_err: got %b, required 0", rx_if.rx_frame_err); end
        checks++; if (rx_if.rx_break !== 1'b0) begin errors++; $display("FAIL reset rx_break: got %b, required 0", rx_if.rx_break); end
        checks++; if (rx_if.rx_busy !== 1'b0) begin errors++; $display("FAIL reset rx_busy: got %b, required 0", rx_if.rx_busy); end
        rst = 1'b0;
        last_byte = 0;
    endtask

    task automatic test_single_byte;
        begin_scn();
        line(1'b1, 10 * DIV);
        busy0 = busy_cnt;
        send_byte(8'h9F);
        line(1'b1, DIV);
        checks++;
        if (busy_cnt - busy0 < HALF + 9 * DIV - 1 || busy_cnt - busy0 > HALF + 9 * DIV + 1) begin
            errors++; $display("FAIL single busy_len: got %0d cycles, required %0d+-1", busy_cnt - busy0, HALF + 9 * DIV);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= obs_q.size()) begin
                errors++; $display("FAIL single ev%0d: missing, required kind=%0d data=%02h", i, exp_q[i].kind, exp_q[i].data);
            end else if (obs_q[base+i].kind != exp_q[i].kind || obs_q[base+i].data != exp_q[i].data ||
                         obs_q[base+i].cyc < exp_q[i].cyc - 1 || obs_q[base+i].cyc > exp_q[i].cyc + 1) begin
                errors++; $display("FAIL single ev%0d: got kind=%0d data=%02h cyc=%0d, required kind=%0d data=%02h cyc=%0d", i,
                    obs_q[base+i].kind, obs_q[base+i].data, obs_q[base+i].cyc, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
            end
        end
        checks++; if (obs_q.size() - base != exp_q.size()) begin errors++; $display("FAIL single count: got %0d events, required %0d", obs_q.size() - base, exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq [7] = '{8'h01, 8'h02, 8'h00, 8'h05, 8'h00, 8'h9F, 8'h00};
        begin_scn();
        foreach (seq[i]) send_byte(seq[i]);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
        line(1'b1, 2 * DIV);
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= obs_q.size()) begin
                errors++; $display("FAIL b2b ev%0d: missing, required kind=%0d data=%02h", i, exp_q[i].kind, exp_q[i].data);
            end else if (obs_q[base+i].kind != exp_q[i].kind || obs_q[base+i].data != exp_q[i].data ||
                         obs_q[base+i].cyc < exp_q[i].cyc - 1 || obs_q[base+i].cyc > exp_q[i].cyc + 1) begin
                errors++; $display("FAIL b2b ev%0d: got kind=%0d data=%02h cyc=%0d, required kind=%0d data=%02h cyc=%0d", i,
                    obs_q[base+i].kind, obs_q[base+i].data, obs_q[base+i].cyc, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
            end
        end
        checks++; if (obs_q.size() - base != exp_q.size()) begin errors++; $display("FAIL b2b count: got %0d events, required %0d", obs_q.size() - base, exp_q.size()); end
    endtask

    task automatic test_glitch;
        int len;
        begin_scn();
        for (int k = 0; k < 3; k++) begin
            len   = (k == 0) ? HALF - 1 : int'($urandom_range(1, HALF - 1));
            busy0 = busy_cnt;
            line(1'b0, len);
            line(1'b1, 2 * DIV);
            checks++;
            if (busy_cnt - busy0 < 1 || busy_cnt - busy0 > HALF + 3) begin
                errors++; $display("FAIL glitch busy_len (pulse %0d): got %0d cycles, required 1..%0d", len, busy_cnt - busy0, HALF + 3);
            end
            checks++; if (rx_if.rx_busy !== 1'b0) begin errors++; $display("FAIL glitch idle: got busy=%b, required 0", rx_if.rx_busy); end
        end
        checks++; if (obs_q.size() - base != 0) begin errors++; $display("FAIL glitch count: got %0d events, required 0", obs_q.size() - base); end
    endtask

    task automatic test_break;
        int nb;
        begin_scn();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h00);
        nb = int'($urandom_range(17, 22));
        send_low(nb);
        checks++; if (rx_if.rx_busy !== 1'b0) begin errors++; $display("FAIL break release: got busy=%b, required 0", rx_if.rx_busy); end
        send_byte(8'h01);
        line(1'b1, 2 * DIV);
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= obs_q.size()) begin
                errors++; $display("FAIL break ev%0d: missing, required kind=%0d data=%02h", i, exp_q[i].kind, exp_q[i].data);
            end else if (obs_q[base+i].kind != exp_q[i].kind || obs_q[base+i].data != exp_q[i].data ||
                         obs_q[base+i].cyc < exp_q[i].cyc - 1 || obs_q[base+i].cyc > exp_q[i].cyc + 1) begin
                errors++; $display("FAIL break ev%0d: got kind=%0d data=%02h cyc=%0d, required kind=%0d data=%02h cyc=%0d", i,
                    obs_q[base+i].kind, obs_q[base+i].data, obs_q[base+i].cyc, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
            end
        end
        checks++; if (obs_q.size() - base != exp_q.size()) begin errors++; $display("FAIL break count: got %0d events, required %0d", obs_q.size() - base, exp_q.size()); end
    endtask

    task automatic test_overrun;
        begin_scn();
        for (int k = 0; k < 2; k++) begin
            send_byte(8'($urandom_range(1, 255)));
            send_low((k == 0) ? 12 : int'($urandom_range(11, 14)));
            send_byte(8'($urandom_range(0, 255)));
            line(1'b1, DIV);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= obs_q.size()) begin
                errors++; $display("FAIL overrun ev%0d: missing, required kind=%0d data=%02h", i, exp_q[i].kind, exp_q[i].data);
            end else if (obs_q[base+i].kind != exp_q[i].kind || obs_q[base+i].data != exp_q[i].data ||
                         obs_q[base+i].cyc < exp_q[i].cyc - 1 || obs_q[base+i].cyc > exp_q[i].cyc + 1) begin
                errors++; $display("FAIL overrun ev%0d: got kind=%0d data=%02h cyc=%0d, required kind=%0d data=%02h cyc=%0d", i,
                    obs_q[base+i].kind, obs_q[base+i].data, obs_q[base+i].cyc, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
            end
        end
        checks++; if (obs_q.size() - base != exp_q.size()) begin errors++; $display("FAIL overrun count: got %0d events, required %0d", obs_q.size() - base, exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b = 8'h3C;
        begin_scn();
        send_byte(8'hA5);
        line(1'b1, DIV);
        line(1'b0, DIV);
        for (int i = 0; i < 4; i++) line(b[i], DIV);
        line(b[4], HALF);
        rst = 1'b1;
        #1;
        checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL rstmid rx_data: got %02h, required 00", rx_if.rx_data); end
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid rx_valid: got %b, required 0", rx_if.rx_valid); end
        checks++; if (rx_if.rx_frame_err !== 1'b0) begin errors++; $display("FAIL rstmid rx_frame_err: got %b, required 0", rx_if.rx_frame_err); end
        checks++; if (rx_if.rx_break !== 1'b0) begin errors++; $display("FAIL rstmid rx_break: got %b, required 0", rx_if.rx_break); end
        checks++; if (rx_if.rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid rx_busy: got %b, required 0", rx_if.rx_busy); end
        last_byte = 0;
        line(b[4], HALF);
        for (int i = 5; i < 8; i++) line(b[i], DIV);
        line(1'b1, 2 * DIV);
        rst = 1'b0;
        line(1'b1, 2 * DIV);
        send_byte(8'h06);
        line(1'b1, 2 * DIV);
        foreach (exp_q[i]) begin
            checks++;
            if (base + i >= obs_q.size()) begin
                errors++; $display("FAIL rstmid ev%0d: missing, required kind=%0d data=%02h", i, exp_q[i].kind, exp_q[i].data);
            end else if (obs_q[base+i].kind != exp_q[i].kind || obs_q[base+i].data != exp_q[i].data ||
                         obs_q[base+i].cyc < exp_q[i].cyc - 1 || obs_q[base+i].cyc > exp_q[i].cyc + 1) begin
                errors++; $display("FAIL rstmid ev%0d: got kind=%0d data=%02h cyc=%0d, required kind=%0d data=%02h cyc=%0d", i,
                    obs_q[base+i].kind, obs_q[base+i].data, obs_q[base+i].cyc, exp_q[i].kind, exp_q[i].data, exp_q[i].cyc);
            end
        end
        checks++; if (obs_q.size() - base != exp_q.size()) begin errors++; $display("FAIL rstmid count: got %0d events, required %0d", obs_q.size() - base, exp_q.size()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_brk.md
Name: uart_rx_brk

Overview:
- UART receiver with break detection for the bootloader top.
- Sits directly downstream of the `uart_rx` pin and upstream of the bootloader command parser.
- Converts the asynchronous 8N1 serial line into byte strobes.
- Flags framing errors, and flags line breaks (line held low for many bit times), which the parser uses to abort an in-progress transfer.

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- UART_BAUDRATE, 9600, line bit rate.
- BREAK_BITS, 16, number of bit periods of continuous low, measured from the start edge, that constitutes a break.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- uart_rx  input  1  raw serial line, asynchronous, idle high.
- rx_data  output  8  last received byte, LSB first on the wire.
- rx_valid  output  1  one-cycle strobe; rx_data is valid this cycle.
- rx_frame_err  output  1  one-cycle strobe; stop bit sampled low.
- rx_break  output  1  one-cycle strobe; break detected.
- rx_busy  output  1  high whenever state != IDLE.

Behaviour:
- Constants: DIV = CLK_FREQ/UART_BAUDRATE (integer division; 1250 at defaults); HALF = DIV/2.
- Bit counter width: clog2(DIV). Low-time counter width: clog2(BREAK_BITS*DIV+1).
- uart_rx passes through a 2-FF synchronizer. Both flops reset to 1. All logic uses the synchronized value rxs.
- Reset: state=IDLE, rx_data=0, all strobes=0, rx_busy=0, counters=0. Reset asserted mid-frame discards the partial byte; no strobe is produced.
- IDLE:
  - rxs==0 → START; bit timer=0; low-time counter=0.
- START:
  - At timer==HALF-1, if rxs==1 (glitch) → IDLE, no strobe.
  - Otherwise → DATA; bit index=0; timer reset.
- DATA:
  - Every DIV cycles, sample rxs into shift register bit[index] (LSB first).
  - After the 8th sample → STOP.
- STOP:
  - After DIV cycles, sample rxs.
  - If 1: rx_data<=shift reg; rx_valid=1 for exactly one cycle; → IDLE.
  - If 0: rx_frame_err=1 for one cycle; rx_data unchanged; → BRK.
- BRK:
  - Low-time counter runs from the START entry and does not restart here.
  - When low-time reaches BREAK_BITS*DIV with rxs still 0: rx_break=1 for one cycle, once per low period.
  - Stay in BRK while rxs==0.
  - On rxs==1 → IDLE. This applies whether or not rx_break fired.
  - A short all-zero overrun (e.g. 12 bit times) gives frame_err only.
- Timing and strobe rules:
  - Sample points are mid-bit: start edge + HALF + k*DIV.
  - rx_valid asserts at start edge (synchronized) + HALF + 9*DIV + 1 cycle.
  - No back-to-back constraint: a start edge seen in the same cycle IDLE is re-entered is processed on the next cycle. One stop bit suffices.
  - The strobes are mutually exclusive in any cycle.
  - rx_valid is never asserted for a frame that produced rx_frame_err.

Decomposition:
- Shared package (bootloader_pkg): state enum {IDLE, START, DATA, STOP, BRK}; DIV/HALF computation as a constant function of CLK_FREQ and UART_BAUDRATE. The same constants are used by the UART transmitter.
- One natural sub-module: sync2 (2-FF synchronizer, reset value parameter). It is reused for spi_si.
- Everything else stays in uart_rx_brk.

Test Plan:
- Idle 10 bit periods, send 0x9F at 9600 baud → exactly one rx_valid, rx_data=0x9F, no frame_err/break; rx_busy high ~9.5 periods.
- Send 0x01,0x02,0x00,0x05,0x00,0x9F,0x00 back-to-back with one stop bit → seven rx_valid strobes carrying those values in order.
- Low pulse of 300 cycles (< HALF) on idle line → no strobes; state returns to IDLE; rx_busy high ≤ HALF+3 cycles.
- Send 0x01,0x02,0x00, then hold line low 19 bit periods, release → one rx_frame_err at ~9.5 periods after break start; one rx_break at 16*1250 cycles after break start; no rx_valid. A following byte 0x01 is received correctly.
- Hold low 12 bit periods, release → rx_frame_err only, no rx_break; the next byte is received correctly.
- Assert rst mid-DATA of a byte → all outputs 0 immediately, no strobe for that frame; after release, byte 0x06 is received correctly.
